hls_engine_job_ctrl: RTL and testbench
======================================

// Module: hls_engine_job_ctrl
// PURPOSE
//  Job sequencer for one HLS engine wrapper (FIFO-fronted accelerator with clear/start/enable ctrl).
//  Accepts a job descriptor, pulses the engine clear, then start; holds enable while running.
//  Counts output-stream handshakes to detect completion. Watchdog on output inactivity.
//  Sits between the HWPE ctrl/regfile FSM and the engine's ctrl_engine_t clear/start/enable fields.
// PARAMETERS
//  CNT_W         16  width of job length and beat counter (output beats)
//  TO_W          20  width of inactivity timeout counter (cycles)
//  CLEAR_CYCLES  2   cycles eng_clear_o is held before start (>=1)
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      reset, synchronous, active-low
//  job_req_i      in   1      job request (level; sampled in IDLE only)
//  job_len_i      in   CNT_W  output beats expected; 0 is illegal
//  job_timeout_i  in   TO_W   max idle cycles between beats; 0 disables watchdog
//  abort_i        in   1      abort current job
//  out_valid_i    in   1      engine output stream valid (snooped)
//  out_ready_i    in   1      engine output stream ready (snooped)
//  job_gnt_o      out  1      1-cycle pulse: job accepted, descriptor latched
//  eng_clear_o    out  1      engine clear
//  eng_start_o    out  1      engine start, 1-cycle pulse
//  eng_enable_o   out  1      engine enable
//  busy_o         out  1      state != IDLE
//  done_o         out  1      1-cycle pulse at job end (any status)
//  status_o       out  2      0 OK, 1 TIMEOUT, 2 ABORT, 3 BADLEN; held until next job_gnt_o
//  beat_cnt_o     out  CNT_W  beats seen in current/last job
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge): state IDLE; all outputs 0, counters 0. Reset mid-job drops job silently.
//  States: IDLE, CLEAR, START, RUN, DONE. All outputs registered (decoded from next state).
//  IDLE: job_req_i=1 -> job_gnt_o=1, latch len/timeout, beat_cnt=0, status=0.
//    len!=0 -> CLEAR. len==0 -> DONE, status=BADLEN.
//  CLEAR: eng_clear_o=1 for exactly CLEAR_CYCLES cycles -> START.
//  START: eng_start_o=1, eng_enable_o=1, one cycle -> RUN.
//  RUN: eng_enable_o=1. Beat = out_valid_i & out_ready_i in START or RUN; beat_cnt++.
//    Beat making beat_cnt==len -> DONE, status=OK.
//  Watchdog (RUN only, timeout!=0): idle counter cleared on each beat and on entering RUN;
//    reaching timeout -> DONE, status=TIMEOUT, eng_clear_o=1 for one cycle in DONE.
//  DONE: done_o=1 one cycle, eng_enable_o=0 -> IDLE.
//  abort_i in CLEAR/START/RUN -> DONE, status=ABORT, eng_clear_o=1 in DONE. abort_i in IDLE/DONE ignored.
//  Priority in one cycle: abort > final beat > timeout.
//  job_req_i outside IDLE ignored (no grant). Beats in IDLE/CLEAR/DONE ignored.
//  Latency: grant at t; clear t+1..t+CLEAR_CYCLES; start t+CLEAR_CYCLES+1; done 1 cycle after final beat.
//  beat_cnt saturates at 2^CNT_W-1; never wraps.
//  Idle counter saturates at 2^TO_W-1.
// STRUCTURE
//  Shared package hls_engine_job_ctrl_package:
//    job_state_e (IDLE/CLEAR/START/RUN/DONE); job_status_e (OK/TIMEOUT/ABORT/BADLEN);
//    JOB_STATUS_W=2.
//  One sub-module: hls_job_watchdog (TO_W): clear/enable/limit in; expired out; zero limit = off.
//  Top: FSM, clear-cycle counter, beat counter, descriptor regs.
// TESTING
//  1 len=4, to=0, CLEAR_CYCLES=2, 4 beats back-to-back from START:
//    -> clear t+1..t+2, start t+3, done 1 cycle after 4th beat, status=0, beat_cnt=4.
//  2 len=0 -> gnt then done next cycle, status=3, no clear/start/enable ever asserted.
//  3 len=8, to=5, stall after 3 beats -> done 5 cycles after 3rd beat;
//    status=1, eng_clear_o=1 with done, beat_cnt=3.
//  4 abort_i during CLEAR, and separately same cycle as final beat -> status=2 in both, done pulse once.
//  5 rst_ni=0 one cycle in RUN -> next cycle all outputs 0, IDLE; no done_o;
//    job_req_i held during job gets exactly one grant.
//  6 len=3 with out_ready_i toggling 1010 and valid held -> only handshakes counted, done after 3rd.

Source files
------------

// File: rtl/hls_engine_job_ctrl_pkg.sv
// rtl/hls_engine_job_ctrl_pkg.sv - shared types for the HLS engine job sequencer
package hls_engine_job_ctrl_package;

  localparam int JOB_STATUS_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    RUN,
    DONE
  } job_state_e;

  typedef enum logic [JOB_STATUS_W-1:0] {
    OK      = 2'd0,
    TIMEOUT = 2'd1,
    ABORT   = 2'd2,
    BADLEN  = 2'd3
  } job_status_e;

endpackage

// File: rtl/hls_engine_job_ctrl_watchdog.sv
// rtl/hls_engine_job_ctrl_watchdog.sv - output inactivity watchdog, zero limit disables it
module hls_job_watchdog #(
  parameter int TO_W = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expired_o
);

  logic [TO_W-1:0] idle_q, idle_d;

  // idle_q is the number of clock edges since the last clear, so expiry
  // puts the job end exactly limit_i cycles after the last beat.
  always_comb begin
    idle_d = idle_q;
    if (clear_i) begin
      idle_d = TO_W'(1);
    end else if (enable_i && (idle_q != {TO_W{1'b1}})) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  always_comb begin
    expired_o = enable_i && !clear_i && (limit_i != '0) &&
                (({1'b0, idle_q} + (TO_W+1)'(1)) >= {1'b0, limit_i});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/hls_engine_job_ctrl.sv
// rtl/hls_engine_job_ctrl.sv - job sequencer driving HLS engine clear/start/enable
module hls_engine_job_ctrl
  import hls_engine_job_ctrl_package::*;
#(
  parameter int CNT_W        = 16,
  parameter int TO_W         = 20,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    job_req_i,
  input  logic [CNT_W-1:0]        job_len_i,
  input  logic [TO_W-1:0]         job_timeout_i,
  input  logic                    abort_i,
  input  logic                    out_valid_i,
  input  logic                    out_ready_i,
  output logic                    job_gnt_o,
  output logic                    eng_clear_o,
  output logic                    eng_start_o,
  output logic                    eng_enable_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [JOB_STATUS_W-1:0] status_o,
  output logic [CNT_W-1:0]        beat_cnt_o
);

  localparam int CLR_W = (CLEAR_CYCLES < 1) ? 1 : $clog2(CLEAR_CYCLES + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES);

  job_state_e       state_q, state_d;
  job_status_e      status_q, status_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic gnt_q, gnt_d;
  logic clear_q, clear_d;
  logic start_q, start_d;
  logic enable_q, enable_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic beat, final_beat, fault_clear, wd_expired;

  hls_job_watchdog #(
    .TO_W(TO_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (beat || (state_q == START)),
    .enable_i  (state_q == RUN),
    .limit_i   (to_q),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    clr_cnt_d   = clr_cnt_q;
    len_d       = len_q;
    to_d        = to_q;
    beat_cnt_d  = beat_cnt_q;
    gnt_d       = 1'b0;
    fault_clear = 1'b0;

    beat = out_valid_i && out_ready_i && ((state_q == START) || (state_q == RUN));
    if (beat && (beat_cnt_q != {CNT_W{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    final_beat = beat && (beat_cnt_d == len_q);

    unique case (state_q)
      IDLE: begin
        if (job_req_i) begin
          gnt_d      = 1'b1;
          len_d      = job_len_i;
          to_d       = job_timeout_i;
          beat_cnt_d = '0;
          status_d   = OK;
          clr_cnt_d  = '0;
          state_d    = CLEAR;
        end
      end
      // The first CLEAR cycle is the grant cycle; the engine clear follows it.
      CLEAR: begin
        if (abort_i) begin
          state_d     = DONE;
          status_d    = ABORT;
          fault_clear = 1'b1;
        end else if ((clr_cnt_q == '0) && (len_q == '0)) begin
          state_d  = DONE;
          status_d = BADLEN;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = START;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      START, RUN: begin
        if (abort_i) begin
          state_d     = DONE;
          status_d    = ABORT;
          fault_clear = 1'b1;
        end else if (final_beat) begin
          state_d  = DONE;
          status_d = OK;
        end else if (wd_expired) begin
          state_d     = DONE;
          status_d    = TIMEOUT;
          fault_clear = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    clear_d  = ((state_d == CLEAR) && (clr_cnt_d != '0)) || fault_clear;
    start_d  = (state_d == START);
    enable_d = (state_d == START) || (state_d == RUN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      status_q   <= OK;
      clr_cnt_q  <= '0;
      len_q      <= '0;
      to_q       <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= 1'b0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      clr_cnt_q  <= clr_cnt_d;
      len_q      <= len_d;
      to_q       <= to_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      clear_q    <= clear_d;
      start_q    <= start_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign job_gnt_o    = gnt_q;
  assign eng_clear_o  = clear_q;
  assign eng_start_o  = start_q;
  assign eng_enable_o = enable_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign status_o     = status_q;
  assign beat_cnt_o   = beat_cnt_q;

endmodule

// File: tb/tb_hls_engine_job_ctrl.sv
// tb/tb_hls_engine_job_ctrl.sv - directed self-checking bench for hls_engine_job_ctrl
module tb_hls_engine_job_ctrl;

  logic        clk;
  logic        rst_n;
  logic        job_req;
  logic [15:0] job_len;
  logic [19:0] job_timeout;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic        gnt, eng_clear, eng_start, eng_enable, busy, done;
  logic [1:0]  status;
  logic [15:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  hls_engine_job_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .job_req_i     (job_req),
    .job_len_i     (job_len),
    .job_timeout_i (job_timeout),
    .abort_i       (abort),
    .out_valid_i   (out_valid),
    .out_ready_i   (out_ready),
    .job_gnt_o     (gnt),
    .eng_clear_o   (eng_clear),
    .eng_start_o   (eng_start),
    .eng_enable_o  (eng_enable),
    .busy_o        (busy),
    .done_o        (done),
    .status_o      (status),
    .beat_cnt_o    (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic launch(input logic [15:0] len, input logic [19:0] to);
    job_req = 1'b1; job_len = len; job_timeout = to;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; job_req = 1'b0; job_len = '0; job_timeout = '0;
    abort = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if ({gnt, eng_clear, eng_start, eng_enable, busy, done, status, beat_cnt} !== 24'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
                         {gnt, eng_clear, eng_start, eng_enable, busy, done, status, beat_cnt});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    launch(16'd4, 20'd0);
    checks++;
    if ({gnt, eng_clear, busy} !== 3'b101) begin
      errors++; $display("FAIL t1_grant: got %b expected 101", {gnt, eng_clear, busy});
    end
    job_req = 1'b0;
    cyc();
    checks++;
    if ({gnt, eng_clear, eng_start} !== 3'b010) begin
      errors++; $display("FAIL t1_clear1: got %b expected 010", {gnt, eng_clear, eng_start});
    end
    cyc();
    checks++;
    if ({eng_clear, eng_start} !== 2'b10) begin
      errors++; $display("FAIL t1_clear2: got %b expected 10", {eng_clear, eng_start});
    end
    cyc();
    checks++;
    if ({eng_clear, eng_start, eng_enable} !== 3'b011) begin
      errors++; $display("FAIL t1_start: got %b expected 011", {eng_clear, eng_start, eng_enable});
    end
    out_valid = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if ({done, eng_enable, eng_start} !== 3'b010 || beat_cnt !== 16'd3) begin
      errors++; $display("FAIL t1_running: got done/en/start=%b cnt=%0d expected 010 cnt=3",
                         {done, eng_enable, eng_start}, beat_cnt);
    end
    cyc();
    out_valid = 1'b0;
    checks++;
    if ({done, eng_enable, eng_clear} !== 3'b100 || status !== 2'd0 || beat_cnt !== 16'd4) begin
      errors++; $display("FAIL t1_done: got done/en/clr=%b status=%0d cnt=%0d expected 100 status=0 cnt=4",
                         {done, eng_enable, eng_clear}, status, beat_cnt);
    end
    cyc();
    checks++;
    if ({done, busy} !== 2'b00 || status !== 2'd0 || beat_cnt !== 16'd4) begin
      errors++; $display("FAIL t1_idle: got done/busy=%b status=%0d cnt=%0d expected 00 status=0 cnt=4",
                         {done, busy}, status, beat_cnt);
    end
  endtask

  task automatic test_badlen();
    logic any_eng;
    launch(16'd0, 20'd0);
    any_eng = eng_clear | eng_start | eng_enable;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL t2_grant: got %b expected 1", gnt);
    end
    job_req = 1'b0;
    cyc();
    any_eng |= eng_clear | eng_start | eng_enable;
    checks++;
    if (done !== 1'b1 || status !== 2'd3) begin
      errors++; $display("FAIL t2_done: got done=%b status=%0d expected done=1 status=3", done, status);
    end
    cyc();
    any_eng |= eng_clear | eng_start | eng_enable;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL t2_idle: got done/busy=%b expected 00", {done, busy});
    end
    checks++;
    if (any_eng !== 1'b0) begin
      errors++; $display("FAIL t2_no_engine_ctrl: got %b expected 0", any_eng);
    end
  endtask

  task automatic test_timeout();
    launch(16'd8, 20'd5);
    job_req = 1'b0;
    cyc(); cyc(); cyc();
    out_valid = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    out_valid = 1'b0;
    checks++;
    if (beat_cnt !== 16'd3) begin
      errors++; $display("FAIL t3_beats: got %0d expected 3", beat_cnt);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (done !== 1'b0 || eng_enable !== 1'b1) begin
      errors++; $display("FAIL t3_not_early: got done=%b en=%b expected done=0 en=1", done, eng_enable);
    end
    cyc();
    checks++;
    if ({done, eng_clear, eng_enable} !== 3'b110 || status !== 2'd1 || beat_cnt !== 16'd3) begin
      errors++; $display("FAIL t3_timeout: got done/clr/en=%b status=%0d cnt=%0d expected 110 status=1 cnt=3",
                         {done, eng_clear, eng_enable}, status, beat_cnt);
    end
    cyc();
    checks++;
    if ({done, eng_clear, busy} !== 3'b000 || status !== 2'd1) begin
      errors++; $display("FAIL t3_after: got done/clr/busy=%b status=%0d expected 000 status=1",
                         {done, eng_clear, busy}, status);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    launch(16'd4, 20'd0);
    job_req = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    ndone += int'(done);
    checks++;
    if ({done, eng_clear, eng_start} !== 3'b110 || status !== 2'd2) begin
      errors++; $display("FAIL t4_abort_clear: got done/clr/start=%b status=%0d expected 110 status=2",
                         {done, eng_clear, eng_start}, status);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); ndone += int'(done);
    end
    checks++;
    if (ndone !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL t4_abort_clear_once: got %0d done pulses busy=%b expected 1 busy=0", ndone, busy);
    end

    ndone = 0;
    launch(16'd2, 20'd0);
    job_req = 1'b0;
    cyc(); cyc(); cyc();
    out_valid = 1'b1; out_ready = 1'b1;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0; out_valid = 1'b0;
    ndone += int'(done);
    checks++;
    if ({done, eng_clear, eng_enable} !== 3'b110 || status !== 2'd2) begin
      errors++; $display("FAIL t4_abort_final: got done/clr/en=%b status=%0d expected 110 status=2",
                         {done, eng_clear, eng_enable}, status);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); ndone += int'(done);
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL t4_abort_final_once: got %0d done pulses expected 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ngnt;
    int ndone;
    ngnt = 0; ndone = 0;
    launch(16'd8, 20'd0);
    ngnt += int'(gnt);
    for (int i = 0; i < 4; i++) begin
      cyc(); ngnt += int'(gnt);
    end
    checks++;
    if (ngnt !== 1 || eng_enable !== 1'b1) begin
      errors++; $display("FAIL t5_one_grant: got %0d grants en=%b expected 1 grant en=1", ngnt, eng_enable);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; job_req = 1'b0;
    ndone += int'(done);
    checks++;
    if ({gnt, eng_clear, eng_start, eng_enable, busy, done, status, beat_cnt} !== 24'h0) begin
      errors++; $display("FAIL t5_reset_outputs: got %h expected 0",
                         {gnt, eng_clear, eng_start, eng_enable, busy, done, status, beat_cnt});
    end
    cyc(); ndone += int'(done);
    cyc(); ndone += int'(done);
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_no_done: got %0d done pulses busy=%b expected 0 busy=0", ndone, busy);
    end
  endtask

  task automatic test_ready_toggle();
    launch(16'd3, 20'd0);
    job_req = 1'b0;
    cyc(); cyc(); cyc();
    out_valid = 1'b1; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (beat_cnt !== 16'd1) begin
      errors++; $display("FAIL t6_cnt1: got %0d expected 1", beat_cnt);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (beat_cnt !== 16'd2 || done !== 1'b0) begin
      errors++; $display("FAIL t6_cnt2: got cnt=%0d done=%b expected cnt=2 done=0", beat_cnt, done);
    end
    cyc();
    out_ready = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL t6_not_early: got done=%b expected 0", done);
    end
    cyc();
    out_ready = 1'b0; out_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || beat_cnt !== 16'd3 || status !== 2'd0) begin
      errors++; $display("FAIL t6_done: got done=%b cnt=%0d status=%0d expected done=1 cnt=3 status=0",
                         done, beat_cnt, status);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    cyc();
    test_badlen();
    cyc();
    test_timeout();
    cyc();
    test_abort();
    cyc();
    test_reset_mid();
    cyc();
    test_ready_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
